// File: rtl/multicycle_alu.sv
// RV32 ALU: single-cycle integer/branch ops plus iterative RV32M multiply/divide
// (one bit per cycle) behind a valid/ready handshake on both sides.
module multicycle_alu #(
  parameter int data_width  = 32,
  parameter int shamt_width = $clog2(data_width)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            alu_op,
  input  logic [data_width-1:0] alu_in_1,
  input  logic [data_width-1:0] alu_in_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] alu_result,
  output logic                  alu_bcond,
  output logic                  busy
);
  localparam int W = data_width;
  localparam logic [shamt_width-1:0] CNT_INIT = shamt_width'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [shamt_width-1:0]   cnt_q, cnt_d;
  logic [4:0]               op_q, op_d;
  logic [W-1:0]             a_q, a_d, b_q, b_d;
  logic [2*W-1:0]           prod_q, prod_d;
  logic                     neg_q, neg_d, div0_q, div0_d;
  logic [W-1:0]             result_q, result_d;
  logic                     bcond_q, bcond_d;

  // Handshake: an op is taken on any edge with in_valid && in_ready; a result
  // is offered while out_valid and retires on the edge where out_ready is high.
  logic accept;
  assign in_ready   = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q == S_MUL) || (state_q == S_DIV);
  assign alu_result = result_q;
  assign alu_bcond  = bcond_q;

  // Single-cycle datapath
  logic [shamt_width-1:0] shamt;
  logic                   lt_s, lt_u, eq;
  logic [W-1:0]           sc_result;
  logic                   sc_bcond;
  assign shamt = alu_in_2[shamt_width-1:0];
  assign lt_s  = $signed(alu_in_1) < $signed(alu_in_2);
  assign lt_u  = alu_in_1 < alu_in_2;
  assign eq    = alu_in_1 == alu_in_2;

  always_comb begin
    sc_result = '0;
    sc_bcond  = 1'b0;
    case (alu_op)
      5'd0:  sc_result = alu_in_1 + alu_in_2;
      5'd1:  sc_result = alu_in_1 - alu_in_2;
      5'd2:  sc_result = alu_in_1 & alu_in_2;
      5'd3:  sc_result = alu_in_1 | alu_in_2;
      5'd4:  sc_result = alu_in_1 ^ alu_in_2;
      5'd5:  sc_result = alu_in_1 << shamt;
      5'd6:  sc_result = alu_in_1 >> shamt;
      5'd7:  sc_result = $signed(alu_in_1) >>> shamt;
      5'd8:  sc_result = {{(W-1){1'b0}}, lt_s};
      5'd9:  sc_result = {{(W-1){1'b0}}, lt_u};
      5'd10: sc_bcond  = eq;
      5'd11: sc_bcond  = !eq;
      5'd12: sc_bcond  = lt_s;
      5'd13: sc_bcond  = !lt_s;
      5'd14: sc_bcond  = lt_u;
      5'd15: sc_bcond  = !lt_u;
      default: ;
    endcase
  end

  // Operand signs only count for the signed flavours; iteration works on magnitudes
  logic         is_mul, is_div, sgn_a, sgn_b;
  logic [W-1:0] mag_a, mag_b;
  assign is_mul = (alu_op[4:2] == 3'b100);
  assign is_div = (alu_op[4:2] == 3'b101);
  assign sgn_a  = alu_in_1[W-1] && (alu_op inside {5'd16, 5'd17, 5'd18, 5'd20, 5'd22});
  assign sgn_b  = alu_in_2[W-1] && (alu_op inside {5'd16, 5'd17, 5'd20, 5'd22});
  assign mag_a  = sgn_a ? -alu_in_1 : alu_in_1;
  assign mag_b  = sgn_b ? -alu_in_2 : alu_in_2;

  // Shift-add multiply step: multiplier sits in the low half and drains out right
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_step, mul_full;
  logic [W-1:0]   mul_result;
  assign mul_sum    = {1'b0, prod_q[2*W-1:W]} + {1'b0, a_q & {W{prod_q[0]}}};
  assign mul_step   = {mul_sum, prod_q[W-1:1]};
  assign mul_full   = neg_q ? -mul_step : mul_step;
  assign mul_result = (op_q[1:0] == 2'b00) ? mul_full[W-1:0] : mul_full[2*W-1:W];

  // Restoring divide step: remainder in the high half, quotient shifts into the low half
  logic [W:0]     div_hi, div_trial;
  logic [2*W-1:0] div_step;
  logic [W-1:0]   div_val, div_result;
  assign div_hi     = prod_q[2*W-1:W-1];
  assign div_trial  = div_hi - {1'b0, b_q};
  assign div_step   = div_trial[W] ? {div_hi[W-1:0], prod_q[W-2:0], 1'b0}
                                   : {div_trial[W-1:0], prod_q[W-2:0], 1'b1};
  assign div_val    = op_q[1] ? div_step[2*W-1:W] : div_step[W-1:0];
  assign div_result = div0_q ? (op_q[1] ? a_q : {W{1'b1}})
                             : (neg_q ? -div_val : div_val);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    result_d = result_q;
    bcond_d  = bcond_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          op_d  = alu_op;
          cnt_d = CNT_INIT;
          if (is_mul) begin
            state_d = S_MUL;
            a_d     = mag_a;
            b_d     = '0;
            prod_d  = {{W{1'b0}}, mag_b};
            neg_d   = sgn_a ^ sgn_b;
            div0_d  = 1'b0;
          end else if (is_div) begin
            // Raw dividend kept for the divide-by-zero remainder
            state_d = S_DIV;
            a_d     = alu_in_1;
            b_d     = mag_b;
            prod_d  = {{W{1'b0}}, mag_a};
            neg_d   = alu_op[1] ? sgn_a : (sgn_a ^ sgn_b);
            div0_d  = (alu_in_2 == '0);
          end else begin
            state_d  = S_DONE;
            result_d = sc_result;
            bcond_d  = sc_bcond;
          end
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        prod_d = mul_step;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = mul_result;
          bcond_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        prod_d = div_step;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = div_result;
          bcond_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      bcond_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      result_q <= result_d;
      bcond_q  <= bcond_d;
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: directed corner cases then randomized ops against
// an arithmetic reference model; inputs driven and outputs sampled on negedge.
module tb_multicycle_alu;
  localparam int W = 32;

  logic         clk = 1'b0, reset_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid, alu_bcond, busy;
  logic [4:0]   alu_op = '0;
  logic [W-1:0] alu_in_1 = '0, alu_in_2 = '0, alu_result;
  int           checks = 0, errors = 0;
  logic [W:0]   exp_q[$];

  multicycle_alu #(.data_width(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .alu_bcond(alu_bcond), .busy(busy)
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the op definitions, using 64-bit arithmetic
  function automatic void ref_alu(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic bc);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sh = b[4:0];
    r  = '0;
    bc = 1'b0;
    p  = '0;
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = a << sh;
      6:  r = a >> sh;
      7:  r = 32'(sa >>> sh);
      8:  r = (sa < sb) ? 32'd1 : 32'd0;
      9:  r = (ua < ub) ? 32'd1 : 32'd0;
      10: bc = (a == b);
      11: bc = (a != b);
      12: bc = (sa < sb);
      13: bc = (sa >= sb);
      14: bc = (ua < ub);
      15: bc = (ua >= ub);
      16: begin p = sa * sb; r = p[31:0]; end
      17: begin p = sa * sb; r = p[63:32]; end
      18: begin p = sa * ub; r = p[63:32]; end
      19: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      20: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      22: r = (b == 0) ? a : 32'(sa % sb);
      23: r = (b == 0) ? a : a % b;
      default: ;
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Driver: called on a negedge; returns on the negedge after the accept edge
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    in_valid = 1'b1;
    alu_op   = op;
    alu_in_1 = a;
    alu_in_2 = b;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: in_ready stayed low for %0d cycles, required high", n);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    alu_op   = 5'($urandom);
    alu_in_1 = $urandom;
    alu_in_2 = $urandom;
  endtask

  // Issue one op, wait for its result and score latency, busy/in_ready, result, bcond
  task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic eb);
    int         lat, busy_n, rdy_n, exp_lat;
    logic [W:0] e;
    exp_q.push_back({eb, er});
    exp_lat = (op >= 16 && op <= 23) ? 33 : 1;
    issue(op, a, b);
    lat = 1; busy_n = 0; rdy_n = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      if (in_ready) rdy_n++;
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_n, exp_lat - 1);
    check({tag, "_ready_while_busy"}, rdy_n, 0);
    check({tag, "_result"}, alu_result, e[W-1:0]);
    check({tag, "_bcond"}, alu_bcond, e[W]);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rr;
    logic         rbc;
    int           ov_n;

    // Reset
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_result", alu_result, 0);
    check("rst_bcond", alu_bcond, 0);

    // Single-cycle directed ops
    run_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
    run_op("sra", 5'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    run_op("blt", 5'd12, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1);
    run_op("bltu", 5'd14, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
    run_op("bge_eq", 5'd13, 32'd5, 32'd5, 32'h0, 1'b1);
    run_op("sltu", 5'd9, 32'h0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    run_op("illegal", 5'd27, 32'h1234, 32'h5678, 32'h0, 1'b0);

    // Multi-cycle directed ops
    run_op("mulh_min", 5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op("div_neg", 5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("rem_neg", 5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_zero", 5'd21, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_zero", 5'd22, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1'b0);
    run_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);

    // Back-to-back single-cycle ops, one result per cycle
    @(negedge clk);
    in_valid = 1'b1; alu_op = 5'd0; alu_in_1 = 32'd10; alu_in_2 = 32'd3;
    @(negedge clk);
    check("b2b_add_valid", out_valid, 1);
    check("b2b_add_result", alu_result, 32'd13);
    check("b2b_ready", in_ready, 1);
    alu_op = 5'd1;
    @(negedge clk);
    check("b2b_sub_valid", out_valid, 1);
    check("b2b_sub_result", alu_result, 32'd7);
    alu_op = 5'd4; alu_in_1 = 32'hF0; alu_in_2 = 32'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_xor_valid", out_valid, 1);
    check("b2b_xor_result", alu_result, 32'h0F);

    // Consumer stall: result must hold and no new op may enter
    @(negedge clk);
    out_ready = 1'b0;
    issue(5'd0, 32'h1234, 32'h1);
    in_valid = 1'b1; alu_op = 5'd0; alu_in_1 = 32'd1; alu_in_2 = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_result", alu_result, 32'h1235);
      check("stall_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("after_stall_result", alu_result, 32'd2);

    // Reset in the middle of a divide aborts it
    issue(5'd21, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_result", alu_result, 0);
    check("abort_busy", busy, 0);
    ov_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) ov_n++;
    end
    check("abort_no_result", ov_n, 0);
    run_op("mul_after_abort", 5'd16, 32'd3, 32'd4, 32'd12, 1'b0);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      ra = pick_operand();
      rb = pick_operand();
      ref_alu(int'(op), ra, rb, rr, rbc);
      run_op($sformatf("rand%0d_op%0d", i, op), op, ra, rb, rr, rbc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Next-generation ALU for the RV32 datapath: a parametrised replacement for the single-cycle combinational ALU.
- Adds signed/unsigned compares, arithmetic shift and SLT/SLTU.
- Adds the RV32M multiply/divide group, computed iteratively at one bit per cycle.
- Sits between ID/EX operand latches and EX/MEM; uses a valid/ready handshake so the hazard unit can stall on multi-cycle ops.

Parameters:
- data_width, 32: operand/result width; must be a power of two, >= 8.
- shamt_width, $clog2(data_width): shift-amount bits taken from alu_in_2.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  operands and op presented
- in_ready  output  1  unit can accept an op this cycle
- alu_op  input  5  operation code, see Behaviour
- alu_in_1  input  data_width  operand A (rs1)
- alu_in_2  input  data_width  operand B (rs2/imm)
- out_valid  output  1  alu_result/alu_bcond valid
- out_ready  input  1  consumer accepts result
- alu_result  output  data_width  registered result
- alu_bcond  output  1  registered branch condition
- busy  output  1  high while in S_MUL or S_DIV

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU
  - 24-31: illegal -> single-cycle, result 0, bcond 0.
- Result/bcond by op class:
  - Branch ops: alu_result = 0, bcond = comparison. BLT/BGE signed, BLTU/BGEU unsigned; BGE is true on equality.
  - Non-branch ops: alu_bcond = 0.
  - Shifts use alu_in_2[shamt_width-1:0] only.
  - SLT/SLTU produce 0 or 1, zero-extended.
- Handshake:
  - Op accepted on an edge where in_valid && in_ready.
  - in_ready = (state==S_IDLE) || (state==S_DONE && out_ready).
  - Result held stable in S_DONE until out_valid && out_ready.
- States: S_IDLE, S_MUL, S_DIV, S_DONE.
  - S_IDLE or S_DONE + accept of ops 0-15 or 24-31 -> S_DONE. Result registered at the accept edge, so out_valid is high the next cycle (latency 1, throughput 1/cycle with out_ready held high).
  - Accept of ops 16-19 -> S_MUL. Shift-add over data_width iterations on magnitudes, with a 2*data_width product register; sign fixed on exit. MUL returns the low half; MULH/MULHSU/MULHU return the high half.
  - Accept of ops 20-23 -> S_DIV. Restoring division over data_width iterations on magnitudes; quotient sign = sign A xor sign B; remainder sign = sign A.
  - S_MUL/S_DIV: counter from data_width-1 down to 0; at 0 -> S_DONE. out_valid asserted exactly data_width+1 cycles after the accept edge. in_ready = 0 and busy = 1 throughout.
  - S_DONE && out_ready && !(in_valid) -> S_IDLE.
  - Operands and op are latched at accept; input changes during iteration have no effect.
- Division corner cases, decided at accept and completing in data_width+1 cycles like any other divide:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = alu_in_1.
  - Signed overflow (A = most negative, B = -1): DIV = A, REM = 0.
- Reset (reset_n = 0 at an edge):
  - state <- S_IDLE, alu_result <- 0, alu_bcond <- 0, out_valid <- 0, busy <- 0, counter <- 0.
  - in_ready reads 1 the cycle after release.
  - Reset mid-iteration aborts the op; no result is ever presented for it.
- Simultaneous events: in S_DONE with out_ready=1 and a new accept, the old result retires and the new op's state is entered on the same edge. There are no bubbles for single-cycle ops.

Test Plan:
- Reset then ADD 0x7FFFFFFF+1 with out_ready=1 -> out_valid next cycle, result 0x80000000, bcond 0; SRA 0x80000000,4 -> 0xF8000000.
- BLT -1,1 -> bcond 1; BLTU -1,1 -> bcond 0; BGE 5,5 -> bcond 1; SLTU 0,0xFFFFFFFF -> 1.
- MULH 0x80000000 x 0x80000000 -> out_valid exactly 33 cycles after accept, result 0x40000000; busy high 32 cycles, in_ready low meanwhile.
- DIV -7,2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 5,0 -> 0xFFFFFFFF; REM 0x80000000,-1 -> 0.
- out_ready held low 5 cycles after ADD result -> result stable and in_ready low; back-to-back ADD/SUB/XOR with out_ready=1 -> one result per cycle.
- reset_n low at iteration 10 of DIVU -> next cycle out_valid=0, in_ready=1, result 0; the following MUL 3x4 -> 12.
